// File: rtl/comptest_pkg.sv
// Shared definitions for the comparator test stand triad decoders.
package comptest_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_S1,
        ST_S2,
        ST_HOLD
    } triad_state_t;

    localparam int unsigned TRIAD_LEN = 3;
    localparam int unsigned HS_PER_CH = 4;
    // Bits following a skipped start bit that cannot begin a new triad
    localparam int unsigned IGN_LEN   = TRIAD_LEN - 1;

    function automatic logic [HS_PER_CH-1:0] hs_onehot(input logic [1:0] code);
        hs_onehot       = '0;
        hs_onehot[code] = 1'b1;
    endfunction

endpackage

// File: rtl/triad_channel.sv
// One distrip channel: triad FSM, hold/ignore timing and saturating hit/skip counters.
module triad_channel
    import comptest_pkg::*;
#(
    parameter int unsigned PERSIST_W = 4,
    parameter int unsigned CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 _reset,
    input  logic                 clr,
    input  logic                 cnt_rst,
    input  logic                 retrig,
    input  logic [PERSIST_W-1:0] persist,
    input  logic                 distrip,
    output logic [HS_PER_CH-1:0] halfstrips,
    output logic                 triad_skip,
    output logic [CNT_W-1:0]     hit_cnt,
    output logic [CNT_W-1:0]     skip_cnt
);

    triad_state_t         state, state_n;
    logic                 b1, b1_n;
    logic [PERSIST_W-1:0] hold_cnt, hold_n;
    logic [1:0]           ign, ign_n;
    logic [HS_PER_CH-1:0] hs_int, hs_n;
    logic                 hit_p, hit_n;
    logic                 skip_n;
    logic                 start_hold;

    always_comb begin
        state_n    = state;
        b1_n       = b1;
        hold_n     = hold_cnt;
        ign_n      = ign;
        hs_n       = hs_int;
        hit_n      = 1'b0;
        skip_n     = 1'b0;
        start_hold = distrip && (ign == '0);
        case (state)
            ST_IDLE: if (distrip) state_n = ST_S1;
            ST_S1: begin
                b1_n    = distrip;
                state_n = ST_S2;
            end
            ST_S2: begin
                hs_n    = hs_onehot({b1, distrip});
                hold_n  = persist;
                hit_n   = 1'b1;
                state_n = ST_HOLD;
            end
            ST_HOLD: begin
                if (ign != '0) ign_n = ign - 2'd1;
                // A retrigger freezes the hold count and keeps the old hit until the new S2
                if (start_hold && retrig) begin
                    state_n = ST_S1;
                end else begin
                    if (start_hold) begin
                        skip_n = 1'b1;
                        ign_n  = 2'(IGN_LEN);
                    end
                    if (hold_cnt != '0) begin
                        hold_n = hold_cnt - PERSIST_W'(1);
                    end else begin
                        hs_n = '0;
                        if (ign == '0 && !start_hold) state_n = ST_IDLE;
                    end
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            state      <= ST_IDLE;
            b1         <= 1'b0;
            hold_cnt   <= '0;
            ign        <= '0;
            hs_int     <= '0;
            hit_p      <= 1'b0;
            halfstrips <= '0;
            triad_skip <= 1'b0;
        end else if (clr) begin
            state      <= ST_IDLE;
            b1         <= 1'b0;
            hold_cnt   <= '0;
            ign        <= '0;
            hs_int     <= '0;
            hit_p      <= 1'b0;
            halfstrips <= '0;
            triad_skip <= 1'b0;
        end else begin
            state      <= state_n;
            b1         <= b1_n;
            hold_cnt   <= hold_n;
            ign        <= ign_n;
            hs_int     <= hs_n;
            hit_p      <= hit_n;
            halfstrips <= hs_int;
            triad_skip <= skip_n;
        end
    end

    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            hit_cnt  <= '0;
            skip_cnt <= '0;
        end else if (cnt_rst) begin
            hit_cnt  <= '0;
            skip_cnt <= '0;
        end else begin
            if (hit_p && hit_cnt != '1) hit_cnt <= hit_cnt + CNT_W'(1);
            if (skip_n && !clr && skip_cnt != '1) skip_cnt <= skip_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/triad_decoder_bank.sv
// Bank of independent triad decoders, one per distrip line, four half-strips each.
module triad_decoder_bank
    import comptest_pkg::*;
#(
    parameter int unsigned NCH       = 8,
    parameter int unsigned PERSIST_W = 4,
    parameter int unsigned CNT_W     = 16
) (
    input  logic                     clk,
    input  logic                     _reset,
    input  logic                     clr,
    input  logic                     cnt_rst,
    input  logic                     retrig,
    input  logic [PERSIST_W-1:0]     persist,
    input  logic [NCH-1:0]           distrip,
    output logic [HS_PER_CH*NCH-1:0] halfstrips,
    output logic [NCH-1:0]           triad_skip,
    output logic [NCH*CNT_W-1:0]     hit_cnt,
    output logic [NCH*CNT_W-1:0]     skip_cnt
);

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        triad_channel #(
            .PERSIST_W(PERSIST_W),
            .CNT_W    (CNT_W)
        ) u_ch (
            .clk       (clk),
            ._reset    (_reset),
            .clr       (clr),
            .cnt_rst   (cnt_rst),
            .retrig    (retrig),
            .persist   (persist),
            .distrip   (distrip[c]),
            .halfstrips(halfstrips[c*HS_PER_CH +: HS_PER_CH]),
            .triad_skip(triad_skip[c]),
            .hit_cnt   (hit_cnt[c*CNT_W +: CNT_W]),
            .skip_cnt  (skip_cnt[c*CNT_W +: CNT_W])
        );
    end

endmodule

// File: tb/tb_triad_decoder_bank.sv
// Directed scoreboard bench for triad_decoder_bank (8 channels, 4-bit counters).
module tb_triad_decoder_bank;

    localparam int unsigned NCH   = 8;
    localparam int unsigned PW    = 4;
    localparam int unsigned CNT_W = 4;

    logic              clk = 1'b0;
    logic              _reset;
    logic              clr;
    logic              cnt_rst;
    logic              retrig;
    logic [PW-1:0]     persist;
    logic [NCH-1:0]    distrip;
    logic [4*NCH-1:0]  halfstrips;
    logic [NCH-1:0]    triad_skip;
    logic [NCH*CNT_W-1:0] hit_cnt;
    logic [NCH*CNT_W-1:0] skip_cnt;

    triad_decoder_bank #(
        .NCH      (NCH),
        .PERSIST_W(PW),
        .CNT_W    (CNT_W)
    ) dut (
        .clk       (clk),
        ._reset    (_reset),
        .clr       (clr),
        .cnt_rst   (cnt_rst),
        .retrig    (retrig),
        .persist   (persist),
        .distrip   (distrip),
        .halfstrips(halfstrips),
        .triad_skip(triad_skip),
        .hit_cnt   (hit_cnt),
        .skip_cnt  (skip_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        int          kind;   // 0 halfstrips, 1 triad_skip, 2 hit_cnt, 3 skip_cnt
        int          ch;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   cyc     = 0;
    int   n_checks = 0;
    int   n_fail  = 0;

    function automatic void push(input int due, input int kind, input int ch, input logic [31:0] v);
        exp_t e;
        e.due  = due;
        e.kind = kind;
        e.ch   = ch;
        e.val  = v;
        sb.push_back(e);
    endfunction

    function automatic void push_hs(input int from, input int to, input logic [31:0] v);
        for (int i = from; i <= to; i++) push(i, 0, 0, v);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s cyc%0d: observed %h expected %h", tag, cyc, obs, expv);
        end
    endtask

    task automatic check_entry(input exp_t e);
        logic [31:0] obs;
        string       tag;
        case (e.kind)
            0: begin obs = halfstrips;                             tag = "halfstrips"; end
            1: begin obs = 32'(triad_skip);                        tag = "triad_skip"; end
            2: begin obs = 32'(hit_cnt[e.ch*CNT_W +: CNT_W]);      tag = $sformatf("hit_cnt[%0d]", e.ch); end
            default: begin obs = 32'(skip_cnt[e.ch*CNT_W +: CNT_W]); tag = $sformatf("skip_cnt[%0d]", e.ch); end
        endcase
        chk(tag, obs, e.val);
    endtask

    task automatic step();
        exp_t keep[$];
        @(posedge clk);
        cyc++;
        #1;
        foreach (sb[i]) begin
            if (sb[i].due == cyc) check_entry(sb[i]);
            else keep.push_back(sb[i]);
        end
        sb = keep;
    endtask

    task automatic drv(input logic [NCH-1:0] d);
        distrip = d;
        step();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drv('0);
    endtask

    initial begin
        int          t;
        logic [31:0] all_hs;
        logic [7:0]  seq[8];

        _reset  = 1'b0;
        clr     = 1'b0;
        cnt_rst = 1'b0;
        retrig  = 1'b0;
        persist = '0;
        distrip = '0;

        #2;
        chk("reset halfstrips", halfstrips, '0);
        chk("reset triad_skip", 32'(triad_skip), '0);
        chk("reset hit_cnt", hit_cnt, '0);
        chk("reset skip_cnt", skip_cnt, '0);
        step();
        step();
        _reset = 1'b1;
        idle(2);

        // Accepted triad on ch2 (1,1,0), persist 5; persist changed mid-hold
        persist = 5;
        t = cyc + 1;
        push_hs(t + 1, t + 2, '0);
        push_hs(t + 3, t + 8, 32'h0000_0400);
        push_hs(t + 9, t + 10, '0);
        push(t + 2, 2, 2, 0);
        push(t + 3, 2, 2, 1);
        for (int i = 1; i <= 8; i++) push(t + i, 1, 0, 0);
        push(t + 10, 3, 2, 0);
        drv(8'h04); drv(8'h04); drv(8'h00);
        persist = 1;
        idle(12);

        // Skip on ch0: triad 1,0,1 then a start two clocks into the hold
        retrig  = 1'b0;
        persist = 7;
        seq = '{8'h1, 8'h0, 8'h1, 8'h0, 8'h0, 8'h1, 8'h1, 8'h1};
        t = cyc + 1;
        push(t + 2, 0, 0, 0);
        push_hs(t + 3, t + 10, 32'h0000_0002);
        push_hs(t + 11, t + 12, '0);
        push(t + 4, 1, 0, 0);
        push(t + 5, 1, 0, 32'h01);
        for (int i = 6; i <= 8; i++) push(t + i, 1, 0, 0);
        push(t + 4, 3, 0, 0);
        push(t + 5, 3, 0, 1);
        push(t + 12, 3, 0, 1);
        push(t + 12, 2, 0, 1);
        for (int i = 0; i < 8; i++) drv(seq[i]);
        idle(12);

        // Retrigger on ch0 with second triad 1,1,1
        cnt_rst = 1'b1;
        push(cyc + 1, 2, 0, 0);
        push(cyc + 1, 3, 0, 0);
        drv('0);
        cnt_rst = 1'b0;
        retrig  = 1'b1;
        seq = '{8'h1, 8'h0, 8'h1, 8'h0, 8'h0, 8'h1, 8'h1, 8'h1};
        t = cyc + 1;
        push_hs(t + 3, t + 7, 32'h0000_0002);
        push_hs(t + 8, t + 15, 32'h0000_0008);
        push(t + 16, 0, 0, 0);
        push(t + 5, 1, 0, 0);
        push(t + 6, 1, 0, 0);
        push(t + 3, 2, 0, 1);
        push(t + 7, 2, 0, 1);
        push(t + 8, 2, 0, 2);
        push(t + 8, 3, 0, 0);
        for (int i = 0; i < 8; i++) drv(seq[i]);
        idle(12);

        // Saturation on ch5: 20 triads at minimum spacing with persist 0
        retrig  = 1'b0;
        persist = 0;
        t = cyc + 1;
        for (int k = 0; k < 20; k++) begin
            int tk;
            tk = t + 4 * k;
            push(tk + 3, 0, 0, 32'h1 << (20 + (k % 4)));
            push(tk + 4, 0, 0, '0);
            push(tk + 3, 2, 5, (k + 1 > 15) ? 15 : k + 1);
        end
        push(t + 79, 3, 5, 0);
        for (int k = 0; k < 20; k++) begin
            drv(8'h20);
            drv(((k % 4) >= 2) ? 8'h20 : 8'h00);
            drv(((k % 4) % 2 == 1) ? 8'h20 : 8'h00);
            drv(8'h00);
        end
        // cnt_rst lands on the same edge as the next hit increment
        t = cyc + 1;
        push(t + 3, 0, 0, 32'h0010_0000);
        push(t + 3, 2, 5, 0);
        push(t + 5, 2, 5, 0);
        drv(8'h20); drv(8'h00); drv(8'h00);
        cnt_rst = 1'b1;
        drv(8'h00);
        cnt_rst = 1'b0;
        idle(4);

        // Start bit on the hold exit cycle (persist 0) is skipped, next two bits ignored
        t = cyc + 1;
        push(t + 3, 0, 0, 32'h0100_0000);
        push_hs(t + 4, t + 10, '0);
        push(t + 3, 1, 0, 32'h40);
        for (int i = 4; i <= 10; i++) push(t + i, 1, 0, 0);
        push(t + 3, 3, 6, 1);
        push(t + 10, 3, 6, 1);
        push(t + 10, 2, 6, 1);
        drv(8'h40); drv(8'h00); drv(8'h00); drv(8'h40); drv(8'h40); drv(8'h40); drv(8'h00);
        idle(6);

        // clr on the b1 cycle of ch3 discards the triad; next clean triad decodes
        persist = 2;
        t = cyc + 1;
        push_hs(t + 1, t + 6, '0);
        push(t + 6, 2, 3, 0);
        push_hs(t + 7, t + 9, 32'h0000_2000);
        push(t + 10, 0, 0, 0);
        push(t + 7, 2, 3, 1);
        drv(8'h08);
        clr = 1'b1;
        drv(8'h08);
        clr = 1'b0;
        drv(8'h00); drv(8'h00);
        drv(8'h08); drv(8'h00); drv(8'h08);
        idle(8);

        // All channels in HOLD, then asynchronous reset between clock edges
        persist = 15;
        all_hs  = '0;
        for (int c = 0; c < 8; c++) all_hs[4 * c + (c % 4)] = 1'b1;
        t = cyc + 1;
        push(t + 3, 0, 0, all_hs);
        push(t + 5, 0, 0, all_hs);
        drv(8'hFF); drv(8'hCC); drv(8'hAA);
        idle(3);
        #3;
        _reset = 1'b0;
        #1;
        chk("async halfstrips", halfstrips, '0);
        chk("async triad_skip", 32'(triad_skip), '0);
        chk("async hit_cnt", hit_cnt, '0);
        chk("async skip_cnt", skip_cnt, '0);
        step();
        chk("held halfstrips", halfstrips, '0);
        _reset = 1'b1;
        idle(3);

        if (sb.size() != 0) begin
            n_checks++;
            n_fail++;
            $error("FAIL scoreboard: observed %0d unchecked entries expected 0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
